// File: rtl/riscv_store_ctrl_if.sv
// Store-request and data-memory write bus bundle for riscv_store_ctrl.
// st_size encoding: 2'd0 byte, 2'd1 halfword, 2'd2 word, 2'd3 invalid.
interface riscv_store_ctrl_if #(
  parameter int WORD_LENGTH = 32,
  parameter int ADDR_WIDTH  = 32
);
  logic                   st_valid;
  logic                   st_ready;
  logic [ADDR_WIDTH-1:0]  st_addr;
  logic [WORD_LENGTH-1:0] st_data;
  logic [1:0]             st_size;
  logic                   st_done;
  logic                   st_err;
  logic                   mem_req;
  logic                   mem_gnt;
  logic                   mem_ack;
  logic [ADDR_WIDTH-1:0]  mem_addr;
  logic [WORD_LENGTH-1:0] mem_wdata;
  logic [3:0]             mem_be;

  modport master (
    input  st_valid, st_addr, st_data, st_size, mem_gnt, mem_ack,
    output st_ready, st_done, st_err, mem_req, mem_addr, mem_wdata, mem_be
  );

  modport slave (
    output st_valid, st_addr, st_data, st_size, mem_gnt, mem_ack,
    input  st_ready, st_done, st_err, mem_req, mem_addr, mem_wdata, mem_be
  );
endinterface

// File: rtl/riscv_store_ctrl.sv
// Store-path sequencer: masks/aligns one store into byte lanes and issues one or
// two aligned write beats, holding st_ready low until the last beat is acked.
module riscv_store_ctrl #(
  parameter int WORD_LENGTH      = 32,
  parameter int ADDR_WIDTH       = 32,
  parameter bit SPLIT_MISALIGNED = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  riscv_store_ctrl_if.master bus
);
  localparam int NUM_LANES = WORD_LENGTH / 8;
  localparam logic [1:0] MASK_B = 2'd0, MASK_H = 2'd1, MASK_X = 2'd2;

  typedef enum logic [2:0] {IDLE, REQ0, WAIT0, REQ1, WAIT1, DONE, ERR} state_t;
  state_t state, state_n;

  logic [NUM_LANES-1:0]     base;
  logic                     size_ok;
  logic [WORD_LENGTH-1:0]   masked;
  logic [2*WORD_LENGTH-1:0] wide;
  logic [2*NUM_LANES-1:0]   be_wide;
  logic [1:0]               off;
  logic                     split, split_q;
  logic                     accept, load_hi;
  logic                     ready, req, done, err;
  logic [ADDR_WIDTH-1:0]    addr_q;
  logic [WORD_LENGTH-1:0]   wdata_q, hi_wdata;
  logic [NUM_LANES-1:0]     be_q, hi_be;

  always_comb begin
    base    = '0;
    size_ok = 1'b1;
    case (bus.st_size)
      MASK_B:  base = 4'b0001;
      MASK_H:  base = 4'b0011;
      MASK_X:  base = 4'b1111;
      default: size_ok = 1'b0;
    endcase
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign masked[8*i +: 8] = bus.st_data[8*i +: 8] & {8{base[i]}};
  end

  // Shifting into a double-width window yields both beats at once: the low half
  // is beat0, whatever spills into the high half is beat1.
  assign off     = bus.st_addr[1:0];
  assign wide    = {{WORD_LENGTH{1'b0}}, masked} << {off, 3'b000};
  assign be_wide = {{NUM_LANES{1'b0}}, base} << off;
  assign split   = |be_wide[2*NUM_LANES-1:NUM_LANES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    ready   = 1'b0;
    req     = 1'b0;
    done    = 1'b0;
    err     = 1'b0;
    accept  = 1'b0;
    load_hi = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (bus.st_valid) begin
          if (!size_ok || (split && !SPLIT_MISALIGNED)) state_n = ERR;
          else begin
            state_n = REQ0;
            accept  = 1'b1;
          end
        end
      end
      REQ0: begin
        req = 1'b1;
        if (bus.mem_gnt) state_n = WAIT0;
      end
      WAIT0: begin
        if (bus.mem_ack) begin
          if (split_q) begin
            state_n = REQ1;
            load_hi = 1'b1;
          end else state_n = DONE;
        end
      end
      REQ1: begin
        req = 1'b1;
        if (bus.mem_gnt) state_n = WAIT1;
      end
      WAIT1: begin
        if (bus.mem_ack) state_n = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_n = IDLE;
      end
      ERR: begin
        err     = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Beat registers only move on accept and on the beat0->beat1 handoff, so the
  // bus sees stable addr/data/be through REQ and WAIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q   <= '0;
      wdata_q  <= '0;
      be_q     <= '0;
      hi_wdata <= '0;
      hi_be    <= '0;
      split_q  <= 1'b0;
    end else if (accept) begin
      addr_q   <= {bus.st_addr[ADDR_WIDTH-1:2], 2'b00};
      wdata_q  <= wide[WORD_LENGTH-1:0];
      be_q     <= be_wide[NUM_LANES-1:0];
      hi_wdata <= wide[2*WORD_LENGTH-1:WORD_LENGTH];
      hi_be    <= be_wide[2*NUM_LANES-1:NUM_LANES];
      split_q  <= split;
    end else if (load_hi) begin
      addr_q  <= addr_q + ADDR_WIDTH'(4);
      wdata_q <= hi_wdata;
      be_q    <= hi_be;
    end
  end

  assign bus.st_ready  = ready;
  assign bus.st_done   = done;
  assign bus.st_err    = err;
  assign bus.mem_req   = req;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_be    = be_q;
endmodule

// File: tb/tb_riscv_store_ctrl.sv
// Randomized store traffic against a byte-level model of the store path, plus
// directed address/size corner cases and a reset-in-flight scenario.
module tb_riscv_store_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  riscv_store_ctrl_if #(.WORD_LENGTH(32), .ADDR_WIDTH(32)) b ();
  riscv_store_ctrl_if #(.WORD_LENGTH(32), .ADDR_WIDTH(32)) b2 ();

  riscv_store_ctrl #(.WORD_LENGTH(32), .ADDR_WIDTH(32), .SPLIT_MISALIGNED(1'b1))
    dut (.clk(clk), .rst_n(rst_n), .bus(b));
  riscv_store_ctrl #(.WORD_LENGTH(32), .ADDR_WIDTH(32), .SPLIT_MISALIGNED(1'b0))
    dut_ns (.clk(clk), .rst_n(rst_n), .bus(b2));

  typedef struct packed {
    logic [31:0] a0, a1, d0, d1;
    logic [3:0]  be0, be1;
    logic        two, err;
  } exp_t;

  int   n_cmp = 0, n_bad = 0;
  exp_t cur;
  bit   fast = 0;
  int   gfix = -1, afix = -1, gmax = 3, amax = 3;
  int   n_end = 0, ncyc = 0, acc = 0, bidx = 0;
  bit   busy = 0, waiting = 0, prev_req = 0, exp_ready = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] expv);
    n_cmp++;
    if (got !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, got, expv);
    end
  endtask

  // Reference: walk the store byte by byte, place each byte at its own address,
  // and group bytes by the word they land in.
  function automatic exp_t model(input logic [31:0] addr, input logic [31:0] data,
                                 input logic [1:0] size, input bit split_en);
    exp_t e;
    int nb;
    logic [31:0] ba, w0;
    logic [1:0] lane;
    e  = '0;
    nb = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : (size == 2'd2) ? 4 : 0;
    w0 = {addr[31:2], 2'b00};
    e.a0 = w0;
    e.a1 = w0 + 32'd4;
    for (int k = 0; k < nb; k++) begin
      ba   = addr + k;
      lane = ba[1:0];
      if ({ba[31:2], 2'b00} == w0) begin
        e.be0[lane] = 1'b1;
        e.d0[8*lane +: 8] = data[8*k +: 8];
      end else begin
        e.two = 1'b1;
        e.be1[lane] = 1'b1;
        e.d1[8*lane +: 8] = data[8*k +: 8];
      end
    end
    e.err = (nb == 0) || (e.two && !split_en);
    return e;
  endfunction

  function automatic int pick(input int fix, input int mx);
    return (fix >= 0) ? fix : int'($urandom_range(mx, 0));
  endfunction

  // Bus responder: grant after a chosen delay, ack a chosen number of cycles later.
  int gcnt = -1, acnt = 0;
  bit wack = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      b.mem_gnt = 1'b0; b.mem_ack = 1'b0; wack = 0; gcnt = -1;
    end else begin
      if (b.mem_ack) b.mem_ack = 1'b0;
      if (b.mem_gnt) begin
        b.mem_gnt = 1'b0;
        acnt = pick(afix, amax);
        if (acnt == 0) b.mem_ack = 1'b1;
        else wack = 1;
      end else if (wack) begin
        acnt--;
        if (acnt == 0) begin b.mem_ack = 1'b1; wack = 0; end
      end else if (b.mem_req) begin
        if (gcnt < 0) gcnt = pick(gfix, gmax);
        if (gcnt == 0) begin b.mem_gnt = 1'b1; gcnt = -1; end
        else gcnt--;
      end
    end
  end

  // Per-cycle compare of the split-enabled DUT against the current expectation.
  always @(negedge clk) begin
    if (!rst_n) begin
      busy = 0; waiting = 0; prev_req = 0; exp_ready = 0; bidx = 0;
    end else begin
      ncyc++;
      if (b.st_done && b.st_err) chk("done_and_err", 1, 0);
      if (exp_ready) begin chk("ready_after_end", b.st_ready, 1); exp_ready = 0; end
      if (busy && b.st_ready) chk("ready_while_busy", b.st_ready, 0);
      if (b.st_valid && b.st_ready) begin busy = 1; acc = ncyc; bidx = 0; end
      if (b.mem_req) begin
        if (!busy || cur.err || bidx >= (cur.two ? 2 : 1)) chk("req_allowed", 0, 1);
        else if (bidx == 0) begin
          chk("beat0_addr", b.mem_addr, cur.a0);
          chk("beat0_wdata", b.mem_wdata, cur.d0);
          chk("beat0_be", b.mem_be, cur.be0);
        end else begin
          chk("beat1_addr", b.mem_addr, cur.a1);
          chk("beat1_wdata", b.mem_wdata, cur.d1);
          chk("beat1_be", b.mem_be, cur.be1);
        end
        waiting = 0;
      end else if (prev_req) begin
        bidx++;
        waiting = 1;
      end
      if (waiting && busy && !b.mem_req)
        chk("be_held_wait", b.mem_be, (bidx == 1) ? cur.be0 : cur.be1);
      if (b.st_done || b.st_err) begin
        chk("end_while_busy", busy, 1);
        chk("req_at_end", b.mem_req, 0);
        chk("end_kind_err", b.st_err, cur.err);
        chk("beats_at_end", bidx, cur.err ? 0 : (cur.two ? 2 : 1));
        if (fast && !cur.err) chk("latency", ncyc - acc, cur.two ? 5 : 3);
        busy = 0; waiting = 0; exp_ready = 1;
        n_end++;
      end
      prev_req = b.mem_req;
    end
  end

  task automatic wait_ready();
    int i;
    for (i = 0; i < 100 && !b.st_ready; i++) begin @(posedge clk); #1; end
    if (!b.st_ready) chk("ready_timeout", 0, 1);
  endtask

  task automatic do_store(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] size);
    int n0;
    cur = model(addr, data, size, 1'b1);
    wait_ready();
    n0 = n_end;
    b.st_valid = 1'b1; b.st_addr = addr; b.st_data = data; b.st_size = size;
    @(posedge clk); #1;
    if (!cur.err) begin
      // Request held during REQ0 must be ignored.
      b.st_addr = $urandom; b.st_data = $urandom; b.st_size = 2'($urandom);
      @(posedge clk); #1;
    end
    b.st_valid = 1'b0;
    for (int i = 0; i < 300 && n_end == n0; i++) @(posedge clk);
    #1;
    if (n_end == n0) chk("end_timeout", 0, 1);
  endtask

  exp_t m;
  logic [31:0] ra;
  initial begin
    b.st_valid = 0; b.st_addr = 0; b.st_data = 0; b.st_size = 0;
    b2.st_valid = 0; b2.st_addr = 0; b2.st_data = 0; b2.st_size = 0;
    b2.mem_gnt = 0; b2.mem_ack = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req", b.mem_req, 0);   chk("rst_addr", b.mem_addr, 0);
    chk("rst_wdata", b.mem_wdata, 0); chk("rst_be", b.mem_be, 0);
    chk("rst_done", b.st_done, 0);  chk("rst_err", b.st_err, 0);
    chk("rst_ready", b.st_ready, 1);
    rst_n = 1'b1;

    // Model pinned by hand-derived values.
    m = model(32'h1003, 32'hDEADBEEF, 2'd0, 1);
    chk("m1_a0", m.a0, 32'h1000); chk("m1_be0", m.be0, 4'b1000);
    chk("m1_d0", m.d0, 32'hEF000000); chk("m1_two", m.two, 0);
    m = model(32'h2002, 32'h1234ABCD, 2'd1, 1);
    chk("m2_be0", m.be0, 4'b1100); chk("m2_d0", m.d0, 32'hABCD0000);
    m = model(32'h3001, 32'hAABBCCDD, 2'd2, 1);
    chk("m3_be0", m.be0, 4'b1110); chk("m3_d0", m.d0, 32'hBBCCDD00);
    chk("m3_a1", m.a1, 32'h3004);  chk("m3_be1", m.be1, 4'b0001);
    chk("m3_d1", m.d1, 32'h000000AA);
    m = model(32'hFFFFFFFF, 32'h0000BEEF, 2'd1, 1);
    chk("m4_a0", m.a0, 32'hFFFFFFFC); chk("m4_be0", m.be0, 4'b1000);
    chk("m4_a1", m.a1, 32'h0); chk("m4_be1", m.be1, 4'b0001);
    m = model(32'hFFFFFFFF, 32'h0000BEEF, 2'd1, 0);
    chk("m4_err_nosplit", m.err, 1);
    m = model(32'h10, 32'h0, 2'd3, 1);
    chk("m_bad_size", m.err, 1);

    fast = 1; gfix = 0; afix = 0;
    do_store(32'h1003, 32'hDEADBEEF, 2'd0);
    do_store(32'h2002, 32'h1234ABCD, 2'd1);
    do_store(32'h3001, 32'hAABBCCDD, 2'd2);
    fast = 0; gfix = 3;
    do_store(32'hFFFFFFFF, 32'h1234BEEF, 2'd1);
    gfix = -1; afix = -1;

    // Split-disabled instance rejects a misaligned half without bus traffic.
    begin
      int errs = 0, reqs = 0;
      @(posedge clk); #1;
      b2.st_valid = 1; b2.st_addr = 32'hFFFFFFFF; b2.st_data = 32'h1234BEEF; b2.st_size = 2'd1;
      @(posedge clk); #1;
      b2.st_valid = 0;
      for (int i = 0; i < 6; i++) begin
        if (i == 0) chk("ns_err_pulse", b2.st_err, 1);
        errs += int'(b2.st_err);
        reqs += int'(b2.mem_req);
        if (b2.st_done) chk("ns_no_done", 1, 0);
        @(posedge clk); #1;
      end
      chk("ns_err_count", errs, 1);
      chk("ns_no_req", reqs, 0);
      chk("ns_ready", b2.st_ready, 1);
    end

    for (int n = 0; n < 300; n++) begin
      ra = $urandom;
      if ($urandom_range(3, 0) == 0) ra = {30'h3FFFFFFF, 2'($urandom)};
      do_store(ra, $urandom, 2'($urandom_range(3, 0)));
    end
    fast = 1; gfix = 0; afix = 0;
    for (int n = 0; n < 30; n++)
      do_store($urandom, $urandom, 2'($urandom_range(2, 0)));
    fast = 0;

    // Reset while waiting for the second beat's ack.
    afix = 12;
    cur = model(32'h3001, 32'hAABBCCDD, 2'd2, 1);
    wait_ready();
    b.st_valid = 1; b.st_addr = 32'h3001; b.st_data = 32'hAABBCCDD; b.st_size = 2'd2;
    @(posedge clk); #1;
    b.st_valid = 0;
    for (int i = 0; i < 100 && !(bidx == 2 && !b.mem_req); i++) begin @(posedge clk); #1; end
    chk("t5_in_wait1", (bidx == 2) && !b.mem_req, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_req", b.mem_req, 0);   chk("t5_addr", b.mem_addr, 0);
    chk("t5_wdata", b.mem_wdata, 0); chk("t5_be", b.mem_be, 0);
    chk("t5_done", b.st_done, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("t5_ready", b.st_ready, 1);
    afix = -1;
    m = model(32'h10, 32'h01020304, 2'd2, 1);
    chk("t5_model_be", m.be0, 4'b1111);
    do_store(32'h10, 32'h01020304, 2'd2);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
